ripple_count_capture: RTL and testbench
=======================================

// Module: ripple_count_capture
// PURPOSE
// - Consumes the raw outputs of a ripple (asynchronously clocked) counter and presents them to clk-domain logic.
// - Synchronizes the value and rejects ripple glitches with a stability filter.
// - Captures a settled value on request and computes the signed-free modular delta since the last capture.
// - Flags wrap-around and hands {count, delta, wrap} to downstream logic over a valid/ready interface.
// PARAMETERS
// - W           3   width of the counter being monitored
// - STABLE_CYC  2   consecutive equal synchronized samples required before a value is accepted (>=1)
// - TIMEOUT     16  max cycles in SETTLE before the capture is abandoned (> STABLE_CYC+2)
// - DOWN        0   0: monitored counter counts up; 1: it counts down
// PORTS
// - clk          in   1   clock
// - rst          in   1   reset, synchronous, active-high
// - cnt_in       in   W   raw ripple counter bits (asynchronous to clk)
// - sample_en    in   1   capture request, level-sensitive, sampled in IDLE
// - out_valid    out  1   capture result available
// - out_ready    in   1   downstream accepts result
// - out_count    out  W   settled counter value
// - out_delta    out  W   counts elapsed since previous accepted capture, modulo 2^W
// - wrap         out  1   counter passed its terminal value since previous capture (valid with out_valid)
// - err_unstable out  1   one-cycle pulse: SETTLE timed out
// BEHAVIOUR
// - Reset (rst=1 at posedge clk) clears all registers and outputs: sync stages, last value and stable counter to 0;
//   out_valid=0, out_count=0, out_delta=0, wrap=0, err_unstable=0; FSM=IDLE. Reset wins over every other input.
// - Synchronizer: s1<=cnt_in; s2<=s1; s2_prev<=s2. No other logic reads cnt_in.
// - Stability filter: if s2==s2_prev, stable_cnt increments, saturating at STABLE_CYC; otherwise it goes to 0.
//   stable = (stable_cnt==STABLE_CYC). The filter runs in all FSM states.
// - FSM:
//   - IDLE:   sample_en=1 -> SETTLE; tmo_cnt<=0.
//   - SETTLE: tmo_cnt increments each cycle.
//     - If stable: register out_count<=s2; out_delta<=DOWN ? last-s2 : s2-last (mod 2^W);
//       wrap<=DOWN ? (s2>last) : (s2<last); out_valid<=1 -> HOLD.
//     - Else if tmo_cnt==TIMEOUT-1: err_unstable=1 for one cycle -> IDLE; no result, last unchanged.
//   - HOLD: out_valid stays high; out_count, out_delta and wrap are frozen.
//     - On out_valid&&out_ready: last<=out_count; out_valid<=0 -> IDLE.
// - Handshake: out_valid never drops without acceptance. Data is stable while valid.
//   sample_en is ignored outside IDLE.
// - A new capture needs at least one IDLE cycle after a handshake, so the minimum spacing between results is
//   2 cycles. sample_en held high gives back-to-back captures.
// - Latency: out_valid is high no later than STABLE_CYC+4 cycles after cnt_in last changes, provided SETTLE is
//   entered before that.
// - The first capture after reset measures from last=0; equal values give delta=0, wrap=0.
// - The delta cannot distinguish whole-modulus multiples. The consumer must sample faster than 2^W counts.
// - rst asserted mid-SETTLE or mid-HOLD aborts the operation. The pending result is lost with no pulse.
// CONFIGURATION
// - RIPPLE_CAPTURE_STATS_EN defined: adds output wrap_total [15:0], reset 0.
//   - It increments by 1 on each accepted handshake with wrap=1 and saturates at 16'hFFFF.
// - Undefined: the port and its counter do not exist; all other behaviour is identical.
// TESTING
// - Reset: hold rst 2 cycles with cnt_in=3'b101 -> all outputs 0, FSM IDLE, and out_valid=0 while rst is high.
// - Basic capture: W=3, DOWN=0, cnt_in=3 steady, pulse sample_en, out_ready=1
//   -> out_count=3, out_delta=3, wrap=0, out_valid high exactly one cycle.
// - Wrap, up: last=6, cnt_in=1 -> out_delta=3, wrap=1.
//   Same with DOWN=1, last=1, cnt_in=6 -> out_delta=3, wrap=1.
// - Backpressure: out_ready=0 for 5 cycles while cnt_in changes 2->4
//   -> out_valid stays 1 and out_count stays 2; the next capture reports delta from 2.
// - Glitch/timeout: toggle cnt_in every cycle during SETTLE -> err_unstable pulses once at cycle TIMEOUT,
//   no out_valid, and last is unchanged.
// - Stats (macro defined): 3 accepted wrapping captures plus 1 non-wrapping capture -> wrap_total=3;
//   rst -> 0. Without the macro the bench must compile with no wrap_total port.

Source files
------------

// File: rtl/ripple_count_capture.sv
// ---------------------------------------------------------------------------
// ripple_count_capture
//
// Brings the raw bits of a ripple counter (clocked asynchronously to clk)
// into the clk domain, waits until the value has stopped rippling, captures
// it on request and reports how far the counter has moved since the last
// accepted capture. Results leave over a valid/ready handshake.
//
// Parameters
//   W           width of the monitored counter
//   STABLE_CYC  equal synchronized samples needed before a value is trusted (>=1)
//   TIMEOUT     cycles allowed in SETTLE before giving up (> STABLE_CYC+2)
//   DOWN        0: monitored counter counts up, 1: it counts down
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset
//   cnt_in        raw ripple counter bits, asynchronous to clk
//   sample_en     capture request, level-sensitive, looked at only in IDLE
//   out_valid     result available; held until accepted
//   out_ready     downstream accepts the result
//   out_count     settled counter value
//   out_delta     counts elapsed since the previous accepted capture, mod 2^W
//   wrap          counter passed its terminal value since the previous capture
//   err_unstable  one-cycle pulse when SETTLE times out
//   wrap_total    (RIPPLE_CAPTURE_STATS_EN only) saturating count of accepted
//                 results that had wrap set
//
// Build option
//   `define RIPPLE_CAPTURE_STATS_EN to add the wrap_total output and its
//   counter. Without it the port does not exist.
// ---------------------------------------------------------------------------
module ripple_count_capture #(
    parameter int W          = 3,
    parameter int STABLE_CYC = 2,
    parameter int TIMEOUT    = 16,
    parameter int DOWN       = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] cnt_in,
    input  logic         sample_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_count,
    output logic [W-1:0] out_delta,
    output logic         wrap,
    output logic         err_unstable
`ifdef RIPPLE_CAPTURE_STATS_EN
    ,
    output logic [15:0]  wrap_total
`endif
);

    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  s1;
    logic [W-1:0]  s2;
    logic [W-1:0]  s2_prev;
    logic [SW-1:0] stable_cnt;
    logic          stable;
    logic [TW-1:0] tmo_cnt;
    logic [W-1:0]  last;
    logic [W-1:0]  delta_next;
    logic          wrap_next;

    // -----------------------------------------------------------------------
    // Two-flop synchronizer plus one history stage for the stability filter.
    // Each bit of a ripple counter changes at a different moment, so s2 may
    // briefly hold a value the counter never had; the filter below rejects it.
    // -----------------------------------------------------------------------
    // NOTE: clocked state is always assigned with <= so every register
    // samples the pre-edge value of the others, giving a real shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            s2_prev <= '0;
        end else begin
            s1      <= cnt_in;
            s2      <= s1;
            s2_prev <= s2;
        end
    end

    // Stability filter: count consecutive equal samples, saturating once the
    // value is trusted. Runs in every FSM state so SETTLE can exit at once if
    // the counter has been quiet for a while.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_cnt <= '0;
        end else if (s2 == s2_prev) begin
            if (!stable) begin
                stable_cnt <= stable_cnt + SW'(1);
            end
        end else begin
            stable_cnt <= '0;
        end
    end

    assign stable = (stable_cnt == SW'(STABLE_CYC));

    // Modular delta and wrap detection against the last accepted value. The
    // W-bit subtraction wraps naturally, which is exactly mod 2^W.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and no latch is inferred.
    always_comb begin
        delta_next = s2 - last;
        wrap_next  = (s2 < last);
        if (DOWN != 0) begin
            delta_next = last - s2;
            wrap_next  = (s2 > last);
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs.
    // IDLE   : wait for sample_en.
    // SETTLE : wait for a trusted value, or give up after TIMEOUT cycles.
    // HOLD   : present the result until the consumer takes it.
    // -----------------------------------------------------------------------
    // NOTE: every register, including the capture history in last, has a
    // reset value so the first delta after reset is measured from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            last         <= '0;
            out_valid    <= 1'b0;
            out_count    <= '0;
            out_delta    <= '0;
            wrap         <= 1'b0;
            err_unstable <= 1'b0;
        end else begin
            err_unstable <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_en) begin
                        tmo_cnt <= '0;
                        state   <= SETTLE;
                    end
                end

                SETTLE: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (stable) begin
                        out_count <= s2;
                        out_delta <= delta_next;
                        wrap      <= wrap_next;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        // Still rippling: drop the request, keep last as is.
                        err_unstable <= 1'b1;
                        state        <= IDLE;
                    end
                end

                HOLD: begin
                    // Result data stays frozen until the handshake; only an
                    // accepted capture becomes the reference for the next one.
                    if (out_ready) begin
                        last      <= out_count;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RIPPLE_CAPTURE_STATS_EN
    // Saturating count of accepted results that reported a wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_total <= '0;
        end else if (out_valid && out_ready && wrap && (wrap_total != 16'hFFFF)) begin
            wrap_total <= wrap_total + 16'd1;
        end
    end
`endif

    // Handshake contract: a pending result neither disappears nor changes
    // until it is accepted, and a timeout reports as a single-cycle pulse.
    a_hold_stable: assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_count) && $stable(out_delta) && $stable(wrap))
    );

    a_err_pulse: assert property (
        @(posedge clk) disable iff (rst)
        err_unstable |=> !err_unstable
    );

endmodule

// File: tb/tb_ripple_count_capture.sv
// ---------------------------------------------------------------------------
// tb_ripple_count_capture
//
// Drives one up-counting and one down-counting instance with the same
// stimulus. Expected results are pushed to a scoreboard queue when a capture
// is requested and popped when the up instance raises out_valid.
// ---------------------------------------------------------------------------
module tb_ripple_count_capture;

    localparam int W          = 3;
    localparam int STABLE_CYC = 2;
    localparam int TIMEOUT    = 16;
    localparam int NVEC       = 7;

    typedef struct {
        logic [W-1:0] cnt;
        logic [W-1:0] d_up;
        logic         w_up;
        logic [W-1:0] d_dn;
        logic         w_dn;
    } vec_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] cnt_in;
    logic         sample_en;
    logic         out_ready;

    logic         valid_u, wrap_u, err_u;
    logic [W-1:0] count_u, delta_u;
    logic         valid_d, wrap_d, err_d;
    logic [W-1:0] count_d, delta_d;
`ifdef RIPPLE_CAPTURE_STATS_EN
    logic [15:0]  wt_u, wt_d;
    int           exp_wt_u;
    int           exp_wt_d;
`endif

    int           n_vec;
    int           n_bad;
    vec_t         sb[$];
    vec_t         cur_exp;
    vec_t         vecs[NVEC];
    logic [W-1:0] m_last;

    ripple_count_capture #(
        .W(W), .STABLE_CYC(STABLE_CYC), .TIMEOUT(TIMEOUT), .DOWN(0)
    ) dut_up (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .sample_en(sample_en),
        .out_valid(valid_u), .out_ready(out_ready), .out_count(count_u),
        .out_delta(delta_u), .wrap(wrap_u), .err_unstable(err_u)
`ifdef RIPPLE_CAPTURE_STATS_EN
        , .wrap_total(wt_u)
`endif
    );

    ripple_count_capture #(
        .W(W), .STABLE_CYC(STABLE_CYC), .TIMEOUT(TIMEOUT), .DOWN(1)
    ) dut_dn (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .sample_en(sample_en),
        .out_valid(valid_d), .out_ready(out_ready), .out_count(count_d),
        .out_delta(delta_d), .wrap(wrap_d), .err_unstable(err_d)
`ifdef RIPPLE_CAPTURE_STATS_EN
        , .wrap_total(wt_d)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: event did not occur in time", name);
    endtask

    // Reference result for a capture of cur given the last accepted value.
    function automatic vec_t mk_exp(input logic [W-1:0] cur);
        vec_t e;
        e.cnt  = cur;
        e.d_up = W'(cur - m_last);
        e.w_up = (cur < m_last);
        e.d_dn = W'(m_last - cur);
        e.w_dn = (cur > m_last);
        return e;
    endfunction

    // Settle cnt_in, then pulse sample_en for one cycle while in IDLE.
    task automatic launch(input vec_t e, input logic ready);
        cnt_in    = e.cnt;
        out_ready = ready;
        repeat (6) @(negedge clk);
        sb.push_back(e);
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output bit ok);
        int n;
        vec_t drop;
        n = 0;
        while (valid_u !== 1'b1 && n < STABLE_CYC + 4) begin
            @(negedge clk);
            n++;
        end
        ok = (valid_u === 1'b1);
        if (!ok) begin
            fail_now({tag, "/valid"});
            if (sb.size() > 0) drop = sb.pop_front();
        end
    endtask

    task automatic compare_result(input string tag);
        if (sb.size() == 0) begin
            fail_now({tag, "/scoreboard"});
            return;
        end
        cur_exp = sb.pop_front();
        check({tag, "/up_count"}, 16'(count_u), 16'(cur_exp.cnt));
        check({tag, "/up_delta"}, 16'(delta_u), 16'(cur_exp.d_up));
        check({tag, "/up_wrap"},  16'(wrap_u),  16'(cur_exp.w_up));
        check({tag, "/dn_valid"}, 16'(valid_d), 16'd1);
        check({tag, "/dn_count"}, 16'(count_d), 16'(cur_exp.cnt));
        check({tag, "/dn_delta"}, 16'(delta_d), 16'(cur_exp.d_dn));
        check({tag, "/dn_wrap"},  16'(wrap_d),  16'(cur_exp.w_dn));
    endtask

    // Accept the pending result and confirm out_valid drops right after.
    task automatic accept(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "/valid_drop_up"}, 16'(valid_u), 16'd0);
        check({tag, "/valid_drop_dn"}, 16'(valid_d), 16'd0);
        out_ready = 1'b0;
        m_last = cur_exp.cnt;
`ifdef RIPPLE_CAPTURE_STATS_EN
        if (cur_exp.w_up) exp_wt_u++;
        if (cur_exp.w_dn) exp_wt_d++;
`endif
    endtask

    task automatic check_stats(input string tag);
`ifdef RIPPLE_CAPTURE_STATS_EN
        check({tag, "/wrap_total_up"}, wt_u, 16'(exp_wt_u));
        check({tag, "/wrap_total_dn"}, wt_d, 16'(exp_wt_d));
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "/valid_up"}, 16'(valid_u), 16'd0);
        check({tag, "/count_up"}, 16'(count_u), 16'd0);
        check({tag, "/delta_up"}, 16'(delta_u), 16'd0);
        check({tag, "/wrap_up"},  16'(wrap_u),  16'd0);
        check({tag, "/err_up"},   16'(err_u),   16'd0);
        check({tag, "/valid_dn"}, 16'(valid_d), 16'd0);
        check({tag, "/err_dn"},   16'(err_d),   16'd0);
        check_stats(tag);
    endtask

    initial begin
        bit   ok;
        vec_t e;
        int   pulses;
        int   pulse_at;
        int   valid_seen;
        int   got;
        bit   phase;

        n_vec  = 0;
        n_bad  = 0;
        m_last = '0;
`ifdef RIPPLE_CAPTURE_STATS_EN
        exp_wt_u = 0;
        exp_wt_d = 0;
`endif

        // {cnt, up delta, up wrap, down delta, down wrap}, chained from last=0
        vecs[0] = '{3'd3, 3'd3, 1'b0, 3'd5, 1'b1};
        vecs[1] = '{3'd6, 3'd3, 1'b0, 3'd5, 1'b1};
        vecs[2] = '{3'd1, 3'd3, 1'b1, 3'd5, 1'b0};
        vecs[3] = '{3'd6, 3'd5, 1'b0, 3'd3, 1'b1};
        vecs[4] = '{3'd6, 3'd0, 1'b0, 3'd0, 1'b0};
        vecs[5] = '{3'd0, 3'd2, 1'b1, 3'd6, 1'b0};
        vecs[6] = '{3'd7, 3'd7, 1'b0, 3'd1, 1'b1};

        // Reset for two cycles with a request pending: reset must win.
        rst       = 1'b1;
        cnt_in    = 3'b101;
        sample_en = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_c1");
        @(negedge clk);
        check_idle_outputs("reset_c2");
        rst       = 1'b0;
        sample_en = 1'b0;

        // Table-driven captures, out_ready held high: one-cycle valid each.
        for (int i = 0; i < NVEC; i++) begin
            launch(vecs[i], 1'b1);
            wait_valid($sformatf("vec%0d", i), ok);
            if (ok) begin
                compare_result($sformatf("vec%0d", i));
                accept($sformatf("vec%0d", i));
            end
        end

        // Backpressure: result for 2 held while the counter moves to 4.
        e = mk_exp(3'd2);
        launch(e, 1'b0);
        wait_valid("bp", ok);
        if (ok) begin
            compare_result("bp");
            cnt_in = 3'd4;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check($sformatf("bp_hold%0d/valid", i), 16'(valid_u), 16'd1);
                check($sformatf("bp_hold%0d/count", i), 16'(count_u), 16'd2);
            end
            accept("bp");
        end
        e = mk_exp(3'd4);
        launch(e, 1'b1);
        wait_valid("bp_next", ok);
        if (ok) begin
            compare_result("bp_next");
            accept("bp_next");
        end

        // Glitching counter: toggle every cycle, starting before the request
        // so the filter is already untrusted when SETTLE is entered.
        phase = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cnt_in = phase ? 3'd1 : 3'd6;
            phase  = ~phase;
            @(negedge clk);
        end
        cnt_in    = phase ? 3'd1 : 3'd6;
        phase     = ~phase;
        sample_en = 1'b1;
        @(negedge clk);
        sample_en  = 1'b0;
        pulses     = 0;
        pulse_at   = -1;
        valid_seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (err_u === 1'b1) begin
                pulses++;
                pulse_at = i;
            end
            if (valid_u === 1'b1 || valid_d === 1'b1) valid_seen++;
            cnt_in = phase ? 3'd1 : 3'd6;
            phase  = ~phase;
            @(negedge clk);
        end
        check("glitch/pulse_count", 16'(pulses), 16'd1);
        check("glitch/pulse_cycle", 16'(pulse_at), 16'(TIMEOUT));
        check("glitch/no_valid",    16'(valid_seen), 16'd0);

        // The abandoned capture must not have moved last (still 4).
        e = mk_exp(3'd5);
        launch(e, 1'b1);
        wait_valid("after_glitch", ok);
        if (ok) begin
            compare_result("after_glitch");
            accept("after_glitch");
        end

        // sample_en held high: two captures back to back, both delta 0.
        out_ready = 1'b1;
        e = mk_exp(3'd5);
        sb.push_back(e);
        sb.push_back(e);
        sample_en = 1'b1;
        got = 0;
        for (int i = 0; i < 12 && got < 2; i++) begin
            @(negedge clk);
            if (valid_u === 1'b1) begin
                compare_result($sformatf("b2b%0d", got));
                got++;
            end
        end
        sample_en = 1'b0;
        check("b2b/results", 16'(got), 16'd2);
        while (sb.size() > 0) cur_exp = sb.pop_front();
        @(negedge clk);
        check("b2b/valid_drop", 16'(valid_u), 16'd0);
        out_ready = 1'b0;
        m_last    = 3'd5;

        check_stats("stats_before_rst");

        // Reset while a result waits in HOLD: it is lost without a pulse.
        e = mk_exp(3'd2);
        launch(e, 1'b0);
        wait_valid("rst_hold", ok);
        if (ok) compare_result("rst_hold");
        rst = 1'b1;
        @(negedge clk);
        m_last = '0;
`ifdef RIPPLE_CAPTURE_STATS_EN
        exp_wt_u = 0;
        exp_wt_d = 0;
`endif
        check_idle_outputs("rst_hold");
        rst = 1'b0;

        // First capture after reset measures from zero again.
        e = mk_exp(3'd3);
        launch(e, 1'b1);
        wait_valid("post_rst", ok);
        if (ok) begin
            compare_result("post_rst");
            accept("post_rst");
        end
        check_stats("stats_final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
